// File: rtl/capture_sequencer_if.sv
`timescale 1ns/1ps
// Control and FIFO-side signal bundle for the capture sequencer.
// master: the Trigger/PIC side that requests captures and reads samples.
// slave:  the sequencer that drives the FIFO enables and status.
interface capture_sequencer_if;
    logic        run;
    logic        single;
    logic        auto_en;
    logic [15:0] pretrig;
    logic        trig;
    logic        pmdc;
    logic        fifo_wren;
    logic        fifo_rden;
    logic        fifo_rst;
    logic        data_ready;
    logic        forced;
    logic [2:0]  state;

    modport master (
        output run, single, auto_en, pretrig, trig, pmdc,
        input  fifo_wren, fifo_rden, fifo_rst, data_ready, forced, state
    );

    modport slave (
        input  run, single, auto_en, pretrig, trig, pmdc,
        output fifo_wren, fifo_rden, fifo_rst, data_ready, forced, state
    );
endinterface

// File: rtl/capture_sequencer.sv
`timescale 1ns/1ps
// Capture controller for the sample FIFO: flush, pre-trigger fill, sliding
// armed window, post-trigger fill, then strobe-paced readout to the PIC.
//
// state   | meaning
// IDLE    | waiting for run or a single request, FIFO untouched
// FLUSH   | FIFO reset held for two cycles, pretrig latched
// PRE     | writing the pre-trigger window
// ARMED   | window slides (write+read) until trig or auto timeout
// POST    | writing the post-trigger remainder
// READOUT | buffer full, one FIFO read per synchronized pmdc rising edge
// DONE    | one cycle, decide between re-arm and IDLE
module capture_sequencer #(
    parameter int          ADDR_W       = 13,
    parameter logic [23:0] AUTO_TIMEOUT = 24'd1000000
) (
    input logic                decim_clk,
    input logic                rst,
    capture_sequencer_if.slave bus
);
    localparam int                 CNT_W   = ADDR_W + 1;
    localparam int                 DEPTH   = 1 << ADDR_W;
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0]  PRE_MAX = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FLUSH   = 3'd1,
        S_PRE     = 3'd2,
        S_ARMED   = 3'd3,
        S_POST    = 3'd4,
        S_READOUT = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pretrig_l_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  rd_cnt_q;
    logic [23:0]       tmo_cnt_q;
    logic              once_l_q;
    logic              pmdc_s1_q;
    logic              pmdc_s2_q;
    logic              pmdc_prev_q;
    logic              fifo_wren_q;
    logic              fifo_rden_q;
    logic              fifo_rst_q;
    logic              data_ready_q;
    logic              forced_q;

    logic [ADDR_W-1:0] pretrig_sat;
    logic              pmdc_rise;
    logic              abort;
    logic              timeout_hit;

    // Clamp the requested window so at least one post-trigger sample remains.
    always_comb begin
        pretrig_sat = PRE_MAX;
        if (32'(bus.pretrig) < 32'(DEPTH - 1)) begin
            pretrig_sat = bus.pretrig[ADDR_W-1:0];
        end
    end

    assign pmdc_rise   = pmdc_s2_q & ~pmdc_prev_q;
    assign abort       = ~bus.run & ~once_l_q;
    assign timeout_hit = bus.auto_en & (tmo_cnt_q == AUTO_TIMEOUT - 24'd1);

    // Sequencer FSM with registered FIFO controls, counters and synchronizer.
    always_ff @(posedge decim_clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pretrig_l_q  <= '0;
            cnt_q        <= '0;
            rd_cnt_q     <= '0;
            tmo_cnt_q    <= '0;
            once_l_q     <= 1'b0;
            pmdc_s1_q    <= 1'b0;
            pmdc_s2_q    <= 1'b0;
            pmdc_prev_q  <= 1'b0;
            fifo_wren_q  <= 1'b0;
            fifo_rden_q  <= 1'b0;
            fifo_rst_q   <= 1'b0;
            data_ready_q <= 1'b0;
            forced_q     <= 1'b0;
        end else begin
            pmdc_s1_q   <= bus.pmdc;
            pmdc_s2_q   <= pmdc_s1_q;
            pmdc_prev_q <= pmdc_s2_q;
            if (bus.single) once_l_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    fifo_wren_q  <= 1'b0;
                    fifo_rden_q  <= 1'b0;
                    fifo_rst_q   <= 1'b0;
                    data_ready_q <= 1'b0;
                    if (bus.run || bus.single || once_l_q) begin
                        state_q     <= S_FLUSH;
                        fifo_rst_q  <= 1'b1;
                        cnt_q       <= CNT_W'(1);
                        pretrig_l_q <= pretrig_sat;
                        forced_q    <= 1'b0;
                        tmo_cnt_q   <= '0;
                        rd_cnt_q    <= '0;
                    end
                end
                S_FLUSH: begin
                    if (cnt_q == '0) begin
                        fifo_rst_q <= 1'b0;
                        if (pretrig_l_q == '0) begin
                            state_q   <= S_ARMED;
                            tmo_cnt_q <= '0;
                        end else begin
                            state_q     <= S_PRE;
                            fifo_wren_q <= 1'b1;
                            cnt_q       <= CNT_W'(pretrig_l_q) - CNT_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_PRE: begin
                    if (abort) begin
                        state_q     <= S_IDLE;
                        fifo_wren_q <= 1'b0;
                        fifo_rden_q <= 1'b0;
                        fifo_rst_q  <= 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q     <= S_ARMED;
                        tmo_cnt_q   <= '0;
                        fifo_rden_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_ARMED: begin
                    if (abort) begin
                        state_q     <= S_IDLE;
                        fifo_wren_q <= 1'b0;
                        fifo_rden_q <= 1'b0;
                        fifo_rst_q  <= 1'b1;
                    end else if (bus.trig || timeout_hit) begin
                        // A real trigger wins a tie with the timeout.
                        state_q     <= S_POST;
                        forced_q    <= ~bus.trig;
                        fifo_wren_q <= 1'b1;
                        fifo_rden_q <= 1'b0;
                        cnt_q       <= DEPTH_C - CNT_W'(pretrig_l_q) - CNT_W'(1);
                    end else if (tmo_cnt_q != '1) begin
                        tmo_cnt_q <= tmo_cnt_q + 24'd1;
                    end
                end
                S_POST: begin
                    if (abort) begin
                        state_q     <= S_IDLE;
                        fifo_wren_q <= 1'b0;
                        fifo_rden_q <= 1'b0;
                        fifo_rst_q  <= 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q      <= S_READOUT;
                        fifo_wren_q  <= 1'b0;
                        data_ready_q <= 1'b1;
                        rd_cnt_q     <= '0;
                        // Forget any strobe history from before the buffer was ready.
                        pmdc_s1_q    <= 1'b0;
                        pmdc_s2_q    <= 1'b0;
                        pmdc_prev_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_READOUT: begin
                    fifo_rden_q <= 1'b0;
                    if (rd_cnt_q == DEPTH_C) begin
                        state_q      <= S_DONE;
                        data_ready_q <= 1'b0;
                    end else if (pmdc_rise) begin
                        fifo_rden_q <= 1'b1;
                        rd_cnt_q    <= rd_cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.run && !once_l_q) begin
                        state_q     <= S_FLUSH;
                        fifo_rst_q  <= 1'b1;
                        cnt_q       <= CNT_W'(1);
                        pretrig_l_q <= pretrig_sat;
                        forced_q    <= 1'b0;
                        tmo_cnt_q   <= '0;
                        rd_cnt_q    <= '0;
                    end else begin
                        state_q  <= S_IDLE;
                        once_l_q <= bus.single;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.fifo_wren  = fifo_wren_q;
    assign bus.fifo_rden  = fifo_rden_q;
    assign bus.fifo_rst   = fifo_rst_q;
    assign bus.data_ready = data_ready_q;
    assign bus.forced     = forced_q;
    assign bus.state      = state_q;
endmodule
